// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / frame demux path.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;

  typedef enum logic [1:0] {P_ADDR, P_COUNT, P_DATA, P_CHECK} parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop input synchronizer plus mid-bit sampling FSM.
// state   | meaning
// IDLE    | line high, waiting for a start edge
// START   | half-bit wait, start bit confirmed or rejected as glitch
// DATA    | sampling 8 data bits, LSB first
// STOP    | mid stop-bit check, emits byte or framing error
// WAIT_HI | after framing error, hold until line returns high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 186
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_rxd,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_valid,
  output logic              o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic              r_sync1;
  logic              r_rxd_s;
  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_shift;

  assign o_byte = r_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rxd_s) begin
            r_cnt   <= HALF_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            if (!r_rxd_s) begin
              r_cnt   <= FULL_LOAD;
              r_bit   <= '0;
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {r_rxd_s, r_shift[BYTE_W-1:1]};
            r_cnt   <= FULL_LOAD;
            if (r_bit == 3'd7) r_state <= STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop-bit keeps back-to-back bytes aligned.
          if (r_cnt == '0) begin
            if (r_rxd_s) begin
              o_byte_valid <= 1'b1;
              r_state      <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WAIT_HI: begin
          if (r_rxd_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_demux.sv
// UART frame demux: addr, count, payload, xor checksum -> per-byte write strobes.
// Optional mid-frame idle timeout enabled by defining UART_TIMEOUT_EN.
// state   | meaning
// P_ADDR  | next byte is the frame address
// P_COUNT | next byte is payload length (0 = 256)
// P_DATA  | payload bytes, each emitted as a write strobe
// P_CHECK | next byte is the xor checksum
module uart_rx_demux
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 186,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  output logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] addr,
  output logic              write,
  output logic              error
);

  if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_rx_demux: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
  end

  logic [BYTE_W-1:0] w_byte;
  logic              w_byte_valid;
  logic              w_frame_err;

  parse_state_t      r_parse;
  logic [BYTE_W-1:0] r_addr;
  logic [BYTE_W-1:0] r_chk;
  logic [8:0]        r_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rxd        (rxd),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

`ifdef UART_TIMEOUT_EN
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                r_tmo <= TMO_LOAD;
    else if (r_parse == P_ADDR || w_byte_valid)  r_tmo <= TMO_LOAD;
    else if (r_tmo != '0)                        r_tmo <= r_tmo - 32'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parse <= P_ADDR;
      r_addr  <= '0;
      r_chk   <= '0;
      r_cnt   <= '0;
      data    <= '0;
      addr    <= '0;
      write   <= 1'b0;
      error   <= 1'b0;
    end else begin
      write <= 1'b0;
      if (w_frame_err) begin
        error   <= 1'b1;
        r_parse <= P_ADDR;
      end else if (w_byte_valid) begin
        case (r_parse)
          P_ADDR: begin
            r_addr  <= w_byte;
            r_chk   <= w_byte;
            r_parse <= P_COUNT;
          end
          P_COUNT: begin
            r_cnt   <= (w_byte == '0) ? 9'd256 : {1'b0, w_byte};
            r_chk   <= r_chk ^ w_byte;
            r_parse <= P_DATA;
          end
          P_DATA: begin
            data  <= w_byte;
            addr  <= r_addr;
            write <= 1'b1;
            r_chk <= r_chk ^ w_byte;
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) r_parse <= P_CHECK;
          end
          P_CHECK: begin
            if (w_byte != r_chk) error <= 1'b1;
            r_parse <= P_ADDR;
          end
          default: r_parse <= P_ADDR;
        endcase
      end
`ifdef UART_TIMEOUT_EN
      else if (r_parse != P_ADDR && r_tmo == '0) begin
        error   <= 1'b1;
        r_parse <= P_ADDR;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_demux.sv
// Self-checking bench for uart_rx_demux: frame table plus hand-written corner sequences.
module tb_uart_rx_demux;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic [7:0] addr;
  logic       write;
  logic       error;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sb [$];
  logic [7:0]  pl [256];
  logic        prev_w = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] n;
    logic [7:0] d [4];
    logic       bad;
    logic       exp_err;
  } vec_t;

  vec_t tbl [3];

  uart_rx_demux #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd     (rxd),
    .data    (data),
    .addr    (addr),
    .write   (write),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write === 1'b1) begin
      check("write_gap", {31'd0, prev_w}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", addr, data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("write_addr", {24'd0, addr}, {24'd0, e[15:8]});
        check("write_data", {24'd0, data}, {24'd0, e[7:0]});
      end
    end
    prev_w = write;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_v;
    idle(CPB);
    rxd = 1'b1;
  endtask

  // Payload comes from pl[]; expected writes are queued before each byte is sent.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] n, input logic bad);
    logic [7:0] chk;
    int         cnt;
    chk = a ^ n;
    cnt = (n == 8'd0) ? 256 : int'(n);
    send_byte(a, 1'b1);
    send_byte(n, 1'b1);
    for (int i = 0; i < cnt; i++) begin
      sb.push_back({a, pl[i]});
      chk = chk ^ pl[i];
      send_byte(pl[i], 1'b1);
    end
    send_byte(chk ^ {7'd0, bad}, 1'b1);
    idle(12);
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data"},  {24'd0, data},  32'd0);
    check({tag, "_addr"},  {24'd0, addr},  32'd0);
    check({tag, "_write"}, {31'd0, write}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{a: 8'h37, n: 8'h02, d: '{8'hAA, 8'h55, 8'h00, 8'h00}, bad: 1'b0, exp_err: 1'b0};
    tbl[1] = '{a: 8'h37, n: 8'h02, d: '{8'hAA, 8'h55, 8'h00, 8'h00}, bad: 1'b1, exp_err: 1'b1};
    tbl[2] = '{a: 8'h35, n: 8'h01, d: '{8'h01, 8'h00, 8'h00, 8'h00}, bad: 1'b0, exp_err: 1'b1};

    reset_n = 1'b0;
    idle(4);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    idle(4);

    // good, bad checksum, then good frame with error still sticky
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) pl[j] = tbl[i].d[j];
      send_frame(tbl[i].a, tbl[i].n, tbl[i].bad);
      check("frame_error", {31'd0, error}, {31'd0, tbl[i].exp_err});
    end

    reset_n = 1'b0;
    idle(2);
    check("reset_clears_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    idle(4);

    // 2-clk glitch while idle
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(40);
    check("glitch_error", {31'd0, error}, 32'd0);
    check("glitch_nowrite", sb.size(), 32'd0);
    pl[0] = 8'h01;
    send_frame(8'h35, 8'h01, 1'b0);
    check("after_glitch_error", {31'd0, error}, 32'd0);

    // 256-byte frame, count byte 0
    for (int i = 0; i < 256; i++) pl[i] = 8'(i);
    send_frame(8'h40, 8'h00, 1'b0);
    check("long_frame_error", {31'd0, error}, 32'd0);

    // framing error on the count byte
    send_byte(8'h41, 1'b1);
    send_byte(8'h03, 1'b0);
    rxd = 1'b0;
    idle(2 * CPB);
    rxd = 1'b1;
    idle(12);
    check("framing_error", {31'd0, error}, 32'd1);
    pl[0] = 8'h5A;
    send_frame(8'h41, 8'h01, 1'b0);
    check("framing_error_sticky", {31'd0, error}, 32'd1);

    // reset in the middle of a payload byte's data bits
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    send_byte(8'h37, 1'b1);
    send_byte(8'h01, 1'b1);
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(CPB);
    rxd = 1'b0;
    idle(CPB / 2);
    reset_n = 1'b0;
    rxd = 1'b1;
    #1;
    check_zero_outputs("midbyte_reset");
    idle(4);
    reset_n = 1'b1;
    idle(3 * CPB * 10);
    check("midbyte_nowrite", sb.size(), 32'd0);
    pl[0] = 8'hC3;
    pl[1] = 8'h3C;
    send_frame(8'h37, 8'h02, 1'b0);
    check("after_reset_error", {31'd0, error}, 32'd0);

`ifdef UART_TIMEOUT_EN
    send_byte(8'h41, 1'b1);
    idle(80);
    check("timeout_early", {31'd0, error}, 32'd0);
    idle(50);
    check("timeout_fired", {31'd0, error}, 32'd1);
    pl[0] = 8'h77;
    send_frame(8'h41, 8'h01, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
